// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Feeds the per-digit 7-segment decoders; result and overflow are held between conversions.
module bin_to_bcd_seq #(
   parameter int BIN_W  = 16,
   parameter int DIGITS = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin_in,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  overflow
);

   localparam int SCR_W = 4 * DIGITS;
   localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t               state_r;
   state_t               state_s;
   logic [BIN_W-1:0]     shift_r;
   logic [SCR_W-1:0]     scratch_r;
   logic [SCR_W-1:0]     adj_s;
   logic [CNT_W-1:0]     cnt_r;
   logic                 sticky_r;
   logic                 busy_r;
   logic                 done_r;
   logic [SCR_W-1:0]     bcd_r;
   logic                 ovf_r;

   function automatic logic [3:0] add3(input logic [3:0] d);
      if (d >= 4'd5) begin
         return d + 4'd3;
      end else begin
         return d;
      end
   endfunction

   // Per-digit add-3 correction on the current scratch value, no inter-digit carry
   always_comb begin
      adj_s = {SCR_W{1'b0}};
      for (int k = 0; k < DIGITS; k++) begin
         adj_s[4*k +: 4] = add3(scratch_r[4*k +: 4]);
      end
   end

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_s = SHIFT;
            end else begin
               state_s = IDLE;
            end
         end
         SHIFT: begin
            if (cnt_r == CNT_W'(BIN_W - 1)) begin
               state_s = DONE;
            end else begin
               state_s = SHIFT;
            end
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Datapath and registered outputs; busy stays high through the done cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_r   <= {BIN_W{1'b0}};
         scratch_r <= {SCR_W{1'b0}};
         cnt_r     <= {CNT_W{1'b0}};
         sticky_r  <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         bcd_r     <= {SCR_W{1'b0}};
         ovf_r     <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
               if (start) begin
                  shift_r   <= bin_in;
                  scratch_r <= {SCR_W{1'b0}};
                  cnt_r     <= {CNT_W{1'b0}};
                  sticky_r  <= 1'b0;
                  busy_r    <= 1'b1;
               end else begin
                  busy_r    <= 1'b0;
               end
            end
            SHIFT: begin
               // Bit leaving the top digit means the value no longer fits
               scratch_r <= {adj_s[SCR_W-2:0], shift_r[BIN_W-1]};
               shift_r   <= shift_r << 1'b1;
               sticky_r  <= sticky_r | adj_s[SCR_W-1];
               cnt_r     <= cnt_r + CNT_W'(1);
               busy_r    <= 1'b1;
               done_r    <= 1'b0;
            end
            DONE: begin
               done_r <= 1'b1;
               bcd_r  <= scratch_r;
               ovf_r  <= sticky_r;
               busy_r <= 1'b1;
            end
            default: begin
               done_r <= 1'b0;
               busy_r <= 1'b0;
            end
         endcase
      end
   end

   assign busy     = busy_r;
   assign done     = done_r;
   assign bcd_out  = bcd_r;
   assign overflow = ovf_r;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: a 5-digit and a 4-digit instance
// checked against a division-based decimal reference model.
module tb_bin_to_bcd_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, start4;
   logic [15:0] bin_in, bin4;
   logic        busy, done, overflow;
   logic        busy4, done4, overflow4;
   logic [19:0] bcd_out;
   logic [15:0] bcd4;

   int passes = 0;
   int total  = 0;

   always #5 clk = ~clk;

   bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
      .busy(busy), .done(done), .bcd_out(bcd_out), .overflow(overflow)
   );

   bin_to_bcd_seq #(.BIN_W(16), .DIGITS(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .bin_in(bin4),
      .busy(busy4), .done(done4), .bcd_out(bcd4), .overflow(overflow4)
   );

   function automatic int unsigned pow10(input int n);
      int unsigned p = 1;
      for (int i = 0; i < n; i++) p = p * 10;
      return p;
   endfunction

   // Low 'digits' decimal digits of v, one nibble each, ones digit lowest
   function automatic logic [19:0] ref_bcd(input int unsigned v, input int digits);
      logic [19:0] r = 20'h0;
      for (int k = 0; k < digits; k++) begin
         r = r | (20'((v / pow10(k)) % 10) << (4 * k));
      end
      return r;
   endfunction

   function automatic logic ref_ovf(input int unsigned v, input int digits);
      return (v >= pow10(digits));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic logic [19:0] cur_bcd(input bit d4);
      return d4 ? {4'h0, bcd4} : bcd_out;
   endfunction

   // One full conversion on either instance, checking hold, latency, busy length and result
   task automatic conv(input bit d4, input logic [15:0] v, input string tag);
      logic [19:0] prev;
      int n, bc, digs;
      digs = d4 ? 4 : 5;
      prev = cur_bcd(d4);
      @(negedge clk);
      if (d4) begin start4 = 1'b1; bin4 = v; end
      else begin start = 1'b1; bin_in = v; end
      @(negedge clk);
      start = 1'b0; start4 = 1'b0;
      bin_in = 16'($urandom); bin4 = 16'($urandom);
      n = 1;
      bc = (d4 ? busy4 : busy) ? 1 : 0;
      chk({tag, "_hold"}, 32'(cur_bcd(d4)), 32'(prev));
      while (!(d4 ? done4 : done) && n < 40) begin
         @(negedge clk);
         n++;
         if (d4 ? busy4 : busy) bc++;
      end
      chk({tag, "_latency"}, 32'(n), 32'd18);
      chk({tag, "_bcd"}, 32'(cur_bcd(d4)), 32'(ref_bcd(v, digs)));
      chk({tag, "_ovf"}, 32'(d4 ? overflow4 : overflow), 32'(ref_ovf(v, digs)));
      chk({tag, "_busycycles"}, 32'(bc), 32'd18);
      @(negedge clk);
      chk({tag, "_busyfall"}, 32'({(d4 ? busy4 : busy), (d4 ? done4 : done)}), 32'd0);
   endtask

   initial begin
      logic [19:0] got;
      logic [15:0] v;
      int nd, last, consec, pd;
      int dpos[$];
      logic [19:0] dval[$];

      rst_n = 1'b0; start = 1'b0; start4 = 1'b0; bin_in = 16'h0; bin4 = 16'h0;
      repeat (3) @(negedge clk);
      chk("reset_main", 32'({busy, done, bcd_out, overflow}), 32'd0);
      chk("reset_d4", 32'({busy4, done4, bcd4, overflow4}), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      conv(1'b0, 16'd0, "zero");
      conv(1'b0, 16'd65535, "max");
      conv(1'b0, 16'd1234, "v1234");

      // start pulse during SHIFT must be ignored
      @(negedge clk); start = 1'b1; bin_in = 16'd4321;
      @(negedge clk); start = 1'b0; bin_in = 16'd0;
      @(negedge clk);
      @(negedge clk); start = 1'b1; bin_in = 16'd777;
      @(negedge clk); start = 1'b0;
      nd = 0; got = 20'h0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) begin nd++; got = bcd_out; end
      end
      chk("ignore_donecount", 32'(nd), 32'd1);
      chk("ignore_bcd", 32'(got), 32'(ref_bcd(4321, 5)));

      // reset in the middle of SHIFT aborts the conversion
      @(negedge clk); start = 1'b1; bin_in = 16'd5555;
      @(negedge clk); start = 1'b0;
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midreset_outputs", 32'({busy, done, bcd_out, overflow}), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      nd = 0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (done) nd++;
      end
      chk("midreset_nodone", 32'(nd), 32'd0);
      conv(1'b0, 16'd9999, "after_reset");

      // 4-digit instance: overflow boundary
      conv(1'b1, 16'd10000, "d4_10000");
      conv(1'b1, 16'd9999, "d4_9999");

      // randomized conversions on both instances
      for (int i = 0; i < 6; i++) begin
         v = 16'($urandom);
         conv(1'b0, v, "rand5");
         v = 16'($urandom_range(0, 20000));
         conv(1'b1, v, "rand4");
      end

      // back-to-back with start held high, bin_in stepping 1,2,3
      @(negedge clk); start = 1'b1; bin_in = 16'd1;
      consec = 0; pd = 0;
      for (int n = 1; n <= 60; n++) begin
         @(negedge clk);
         if (n == 1) bin_in = 16'd2;
         if (n == 19) bin_in = 16'd3;
         if (n == 37) start = 1'b0;
         if (done) begin dpos.push_back(n); dval.push_back(bcd_out); end
         if (done && pd != 0) consec++;
         pd = done ? 1 : 0;
      end
      chk("b2b_count", 32'(dpos.size()), 32'd3);
      chk("b2b_consec", 32'(consec), 32'd0);
      if (dpos.size() == 3) begin
         last = 0;
         for (int i = 0; i < 3; i++) begin
            chk("b2b_pos", 32'(dpos[i] - last), 32'd18);
            chk("b2b_val", 32'(dval[i]), 32'(ref_bcd(i + 1, 5)));
            last = dpos[i];
         end
      end else begin
         chk("b2b_shape", 32'(dpos.size()), 32'd3);
      end

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Produces the 4-bit decimal digits that feed the team's 7-segment digit decoders, for example to display a register or PC value from the pipeline.
- Sits upstream of the per-digit segment decoders.
- Uses a start/busy/done handshake and holds its result until the next conversion completes.

Parameters:
- BIN_W, 16: width of the binary input.
- DIGITS, 5: number of BCD output digits. Any value 1 or greater is legal; overflow is flagged when the result does not fit.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  conversion request, sampled only while idle.
- bin_in  input  BIN_W  unsigned value, captured in the cycle start is accepted.
- busy  output  1  high while a conversion is in progress, including the done cycle.
- done  output  1  one-cycle pulse; bcd_out and overflow are updated in the same cycle.
- bcd_out  output  4*DIGITS  result digits; digit k occupies bits [4k+3:4k], and digit 0 is the ones digit.
- overflow  output  1  high when the input value exceeds 10^DIGITS - 1; updated with done.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state goes to IDLE.
  - busy=0, done=0, bcd_out=0, overflow=0.
  - Internal shift register, scratch digits and counter are cleared.
  - Reset mid-conversion aborts it; no done pulse is produced for the aborted request.
- FSM states: IDLE, SHIFT, DONE. busy is high whenever state is not IDLE.
- IDLE:
  - If start=1, latch bin_in into the shift register, clear the scratch BCD (4*DIGITS bits), clear the counter and the overflow sticky bit, then go to SHIFT.
  - If start=0, stay in IDLE. All outputs hold.
- SHIFT, one iteration per cycle:
  - For each scratch digit, if the digit is 5 or more, add 3. This is done combinationally on the current value, for all digits in parallel.
  - Shift {scratch, shift_reg} left by 1. The MSB of the shift register enters bit 0 of scratch.
  - The bit shifted out of the top scratch digit ORs into the overflow sticky bit.
  - The counter increments. When the counter equals BIN_W-1 in this cycle, go to DONE.
  - Exactly BIN_W SHIFT cycles occur.
- DONE (exactly one cycle):
  - done=1; bcd_out takes the scratch value; overflow takes the sticky bit.
  - Go to IDLE. busy falls on the following cycle.
- Latency: if start is accepted at edge T, SHIFT runs for edges T+1 through T+BIN_W, and done is high during the cycle after edge T+BIN_W+1. Total is BIN_W+2 cycles from the start edge to the return to IDLE.
- start while busy (SHIFT or DONE) is ignored and is not queued. bin_in changes during a conversion have no effect.
- Back-to-back: start held high continuously produces one conversion every BIN_W+2 cycles; each one captures bin_in at its accepting edge.
- bcd_out and overflow hold their previous result throughout a conversion. They change only in the DONE cycle.
- On overflow, bcd_out holds the low DIGITS decimal digits produced by the algorithm. Consumers must check overflow.
- done never asserts in two consecutive cycles.
- Arithmetic: every digit stays in the range 0..9 after each iteration. The add-3 operates within 4 bits with no carry between digits.

Test Plan:
- Defaults, bin_in=0, start pulse: done after 18 cycles; bcd_out=20'h00000; overflow=0; busy high for exactly 18 cycles.
- bin_in=16'd65535: bcd_out=20'h65535, overflow=0. Then bin_in=16'd1234: bcd_out=20'h01234. Previous result is held until the second done.
- Pulse start again 3 cycles after the first accepted start, with a different bin_in: ignored; a single done carries the first value's result.
- Assert rst_n=0 mid-SHIFT, for example at cycle 7: all outputs are 0 immediately, no done pulse follows, and a new start afterwards converts 16'd9999 to 20'h09999.
- DIGITS=4, bin_in=16'd10000: overflow=1, bcd_out=16'h0000. Then 16'd9999: overflow=0, bcd_out=16'h9999.
- Hold start=1 with bin_in stepping 1, 2, 3 at each accepting edge: done pulses spaced 18 cycles apart with bcd_out 1, 2, 3. done is never high in consecutive cycles.
